// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
// Contents: frame FSM state type, odd-parity helper, default
// parameter values and the break-prefix scan code for consumers.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam int unsigned DEF_FILTER_LEN  = 8;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 50000;

  // Scan code that precedes a key-release code.
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  // True when data plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan_fifo_if.sv
// Scan-code output channel of the PS/2 receiver.
// master (receiver): drives code_valid, code_data, fifo_count; reads code_ready.
// slave (consumer) : reads code_valid, code_data, fifo_count; drives code_ready.
interface ps2_scan_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  logic                    code_valid;
  logic                    code_ready;
  logic [7:0]              code_data;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output code_valid,
    output code_data,
    output fifo_count,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code_data,
    input  fifo_count,
    output code_ready
  );
endinterface

// File: rtl/ps2_edge_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on clock and data, a glitch
// filter on the clock and a one-cycle strobe on each filtered falling edge.
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   ps2_clk_i      raw PS/2 clock pin (asynchronous)
//   ps2_dat_i      raw PS/2 data pin (asynchronous)
//   fall_o         one-cycle strobe on a filtered clock falling edge
//   dat_o          synchronised data pin
module ps2_edge_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic fall_o,
  output logic dat_o
);
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_q;
  logic          fall_q;
  logic [CW-1:0] run_q;

  // run_q counts consecutive synchronised samples that disagree with the
  // filtered level; the level flips once FILTER_LEN of them are seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      fall_q     <= 1'b0;
      run_q      <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      fall_q     <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        run_q <= '0;
      end else if (run_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= clk_sync_q[1];
        run_q  <= '0;
        fall_q <= filt_q;
      end else begin
        run_q <= run_q + CW'(1);
      end
    end
  end

  assign fall_o = fall_q;
  assign dat_o  = dat_sync_q[1];

endmodule

// File: rtl/ps2_scan_fifo.sv
// PS/2 device-to-host receiver with scan-code FIFO, clocked by clock50 only.
// Ports:
//   clock50, reset  system clock, synchronous active-high reset
//   ps2_clk/ps2_dat raw PS/2 pins
//   code_if         valid/ready scan-code output with fill level
//   parity_err      one-cycle pulse: frame rejected for parity
//   frame_err       one-cycle pulse: stop bit 0 or frame timeout
//   overflow        one-cycle pulse: good byte dropped, FIFO full
module ps2_scan_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN   = DEF_FILTER_LEN,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter bit          CHECK_PARITY = 1'b1
) (
  input  logic            clock50,
  input  logic            reset,
  input  logic            ps2_clk,
  input  logic            ps2_dat,
  ps2_scan_fifo_if.master code_if,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic fall;
  logic dat;

  ps2_edge_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_edge_filter (
    .clk_i    (clock50),
    .rst_i    (reset),
    .ps2_clk_i(ps2_clk),
    .ps2_dat_i(ps2_dat),
    .fall_o   (fall),
    .dat_o    (dat)
  );

  // ---------------- frame FSM and timeout ----------------
  ps2_state_e    state_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] to_cnt_q;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          push;

  assign push = (state_q == STOP) && fall && dat &&
                (!CHECK_PARITY || odd_parity_ok(shift_q, parity_q));

  always_ff @(posedge clock50) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q == IDLE || fall) to_cnt_q <= '0;
      else                         to_cnt_q <= to_cnt_q + TW'(1);

      if (state_q != IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        frame_err_q <= 1'b1;
        state_q     <= IDLE;
        bit_idx_q   <= '0;
        shift_q     <= '0;
        to_cnt_q    <= '0;
      end else if (fall) begin
        unique case (state_q)
          IDLE: begin
            if (!dat) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {dat, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= dat;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dat) frame_err_q <= 1'b1;
            else if (CHECK_PARITY && !odd_parity_ok(shift_q, parity_q)) parity_err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // ---------------- scan-code FIFO ----------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic          overflow_q;
  logic          full;
  logic          pop;
  logic          do_push;

  assign full    = (cnt_q == FULL_CNT);
  assign pop     = (cnt_q != '0) && code_if.code_ready;
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clock50) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && full && !pop;
      if (do_push) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      unique case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign code_if.code_valid = (cnt_q != '0);
  assign code_if.code_data  = mem_q[rd_q];
  assign code_if.fifo_count = cnt_q;
  assign parity_err         = parity_err_q;
  assign frame_err          = frame_err_q;
  assign overflow           = overflow_q;

endmodule

// File: doc/ps2_scan_fifo.md
# ps2_scan_fifo

Parametrised PS/2 device-to-host receiver with integrated scan-code FIFO, the next generation of our keyboard front end. Runs entirely on the 50 MHz system clock, with no logic clocked by the PS/2 clock. Adds input synchronisation, a glitch filter, odd-parity and stop-bit checking, frame timeout recovery and a DEPTH-entry FIFO with a valid/ready output. It sits between the PS/2 pins and consumers such as the HEX history display and the LCD formatter.

## Interface
- FILTER_LEN, 8: consecutive equal samples required before the filtered PS/2 clock changes level.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYC, 50000: idle clock cycles inside a frame before it is aborted (1 ms at 50 MHz).
- CHECK_PARITY, 1: 1 enforces odd parity; 0 ignores the parity bit.

Ports:
- clock50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- code_valid  out  1  FIFO non-empty; code_data is valid.
- code_ready  in  1  consumer accepts the head entry.
- code_data  out  8  head scan code.
- fifo_count  out  $clog2(DEPTH)+1  number of stored entries.
- parity_err  out  1  one-cycle pulse: frame rejected for parity.
- frame_err  out  1  one-cycle pulse: stop bit was 0, or timeout.
- overflow  out  1  one-cycle pulse: good frame dropped because the FIFO was full.

## Operation
- Both pins pass through a 2-FF synchroniser. The filtered clock goes to 1 (or 0) only after FILTER_LEN consecutive synchronised samples of 1 (or 0). A falling edge of the filtered clock produces a one-cycle `fall` strobe.
- All frame FSM transitions occur only on `fall`, except timeout and reset. Data is sampled from the synchronised ps2_dat.
- FSM states:
  - IDLE: if dat=0, go to DATA with bit index 0. If dat=1, stay in IDLE; the edge is ignored.
  - DATA: shift the bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: go to IDLE. The checks are applied in this order:
    - dat=0: frame_err pulse.
    - CHECK_PARITY=1 and (^data ^ parity)=0: parity_err pulse.
    - Otherwise: push the byte.
- Timeout:
  - A cycle counter runs in any non-IDLE state and clears on every `fall`.
  - When it reaches TIMEOUT_CYC: frame_err pulse, go to IDLE, discard the partial byte.
- FIFO:
  - Circular buffer with a DEPTH-entry read pointer and write pointer; pointers wrap modulo DEPTH.
  - code_valid = (fifo_count != 0). code_data = entry at the read pointer; it holds when code_valid=0.
  - Pop occurs when code_valid && code_ready.
  - Push while full drops the new byte and pulses overflow; existing contents are unchanged.
  - Simultaneous push and pop while full: both happen, count stays at DEPTH, no overflow.
  - Simultaneous push and pop while empty: only the push happens (pop is not permitted when code_valid=0).
- Reset:
  - State IDLE; pointers, count, bit index and timeout counter cleared to 0; all error pulses 0.
  - Filter state preset to 1 (line idle-high).
  - A frame in flight at reset is discarded and never produces an error pulse.

## Timing
- Pin to `fall`: 2 synchroniser cycles plus FILTER_LEN cycles.
- The push takes effect on the clock edge where STOP processes `fall`. code_valid and fifo_count update in the following cycle.
- Error and overflow pulses are high for exactly one cycle, in the cycle after the deciding `fall` or timeout event.
- Pop: code_data shows the next entry and fifo_count decrements one cycle after the valid&&ready edge.
- Back-to-back pops at one per cycle are supported.
- Reset values of all outputs: code_valid=0, code_data=8'h00, fifo_count=0, parity_err=0, frame_err=0, overflow=0.

## Structure
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Odd-parity function.
  - Default constants: FILTER_LEN, DEPTH, TIMEOUT_CYC.
  - Break prefix constant 8'hF0, for consumers.
- Sub-module ps2_edge_filter: synchroniser, glitch filter and `fall` strobe, with the synchronised data as output. It is also reusable for a future host-to-device transmitter.
- FIFO, FSM and timeout counter are inline in ps2_scan_fifo.

## Test plan
- Valid frame 0x1C (start 0, data LSB-first, parity 0, stop 1) with code_ready=0 -> code_valid=1, code_data=8'h1C, fifo_count=1, no error pulses.
- Frame 0x1C with parity bit 1 -> one parity_err pulse, fifo_count stays 0. Repeat with CHECK_PARITY=0 -> 0x1C is pushed.
- Frame 0x5A with stop bit 0 -> one frame_err pulse, no push.
- DEPTH=4, code_ready=0, send 0x11, 0x22, 0x33, 0x44, 0x55 -> overflow pulses once, on the fifth frame; fifo_count=4. Then hold code_ready=1 -> pops yield 11, 22, 33, 44 on consecutive cycles, then code_valid=0.
- Pulses on ps2_clk low for FILTER_LEN-2 cycles between frames -> no bits sampled. A following 0xF0 frame is received correctly.
- Stop clocking after 4 data bits -> frame_err after TIMEOUT_CYC cycles, FSM returns to IDLE, next frame 0x29 is received. Separately, assert reset mid-frame -> all outputs 0, no error pulse, next frame is received.
